// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard controller and its in-flight scoreboard.
// Register indices up to REG_ADDR_MAX bits and pipelines up to 8 stages are supported.
package hazard_pkg;

    localparam int REG_ADDR_MAX = 8;
    localparam int FSEL_MAX     = 4;

    localparam logic [FSEL_MAX-1:0] FSEL_REGFILE = '0;

    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_MAX-1:0] rd;
        logic                    regwen;
        logic                    is_load;
    } sb_entry_t;

    // Stage k is reached through select code k+1; code 0 is the register file.
    function automatic logic [FSEL_MAX-1:0] stage_to_fsel(input int stage);
        return FSEL_MAX'(stage + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight instructions, entry 0 = EX, entry DEPTH-1 = WB.
// Advances every cycle; a bubble inserts an invalid entry at EX.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_bubble,
    input  sb_entry_t             i_entry,
    output sb_entry_t [DEPTH-1:0] o_entries
);

    sb_entry_t [DEPTH-1:0] r_entries;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entries <= '0;
        end else begin
            r_entries[0] <= i_bubble ? sb_entry_t'('0) : i_entry;
            for (int i = 1; i < DEPTH; i++) begin
                r_entries[i] <= r_entries[i-1];
            end
        end
    end

    assign o_entries = r_entries;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forward selects, load-use stall and redirect squash.
// Define HAZARD_STATS_EN to add saturating stall/flush counters (stall_cnt, flush_cnt).
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_LENGTH = 5,
    parameter int DEPTH           = 3,
    parameter int ALU_READY       = 1,
    parameter int LOAD_READY      = 2,
    parameter int FSEL_W          = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [REG_ADDR_LENGTH-1:0] id_rs1,
    input  logic [REG_ADDR_LENGTH-1:0] id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [REG_ADDR_LENGTH-1:0] id_rd,
    input  logic                       id_regwen,
    input  logic                       id_is_load,
    input  logic                       ex_redirect,
    output logic                       stall,
    output logic                       flush_ifid,
    output logic                       bubble_ex,
    output logic [FSEL_W-1:0]          fwd_a,
`ifdef HAZARD_STATS_EN
    output logic [FSEL_W-1:0]          fwd_b,
    output logic [15:0]                stall_cnt,
    output logic [15:0]                flush_cnt
`else
    output logic [FSEL_W-1:0]          fwd_b
`endif
);

    sb_entry_t [DEPTH-1:0] w_entries;
    sb_entry_t             w_new_entry;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic                  w_load_a;
    logic                  w_load_b;
    int                    w_stage_a;
    int                    w_stage_b;
    logic                  w_ready_a;
    logic                  w_ready_b;
    logic                  w_hazard;
    logic [FSEL_W-1:0]     w_fwd_a_next;
    logic [FSEL_W-1:0]     w_fwd_b_next;
    logic                  w_unused_wb;

    assign w_new_entry = '{valid:   id_valid,
                           rd:      REG_ADDR_MAX'(id_rd),
                           regwen:  id_regwen,
                           is_load: id_is_load};

    hazard_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bubble  (bubble_ex),
        .i_entry   (w_new_entry),
        .o_entries (w_entries)
    );

    // The WB entry has already written the register file when the consumer reaches EX.
    assign w_unused_wb = ^w_entries[DEPTH-1];

    function automatic logic produces(input sb_entry_t e,
                                      input logic [REG_ADDR_LENGTH-1:0] src,
                                      input logic used);
        return e.valid && e.regwen && used && (src != '0) &&
               (e.rd == REG_ADDR_MAX'(src));
    endfunction

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        w_hit_a   = 1'b0;
        w_load_a  = 1'b0;
        w_stage_a = 0;
        w_hit_b   = 1'b0;
        w_load_b  = 1'b0;
        w_stage_b = 0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (produces(w_entries[k], id_rs1, id_rs1_used)) begin
                w_hit_a   = 1'b1;
                w_load_a  = w_entries[k].is_load;
                w_stage_a = k;
            end
            if (produces(w_entries[k], id_rs2, id_rs2_used)) begin
                w_hit_b   = 1'b1;
                w_load_b  = w_entries[k].is_load;
                w_stage_b = k;
            end
        end
    end

    assign w_ready_a = (w_stage_a + 1) >= (w_load_a ? LOAD_READY : ALU_READY);
    assign w_ready_b = (w_stage_b + 1) >= (w_load_b ? LOAD_READY : ALU_READY);
    assign w_hazard  = id_valid && ((w_hit_a && !w_ready_a) || (w_hit_b && !w_ready_b));

    always_comb begin
        stall      = 1'b0;
        flush_ifid = 1'b0;
        bubble_ex  = 1'b0;
        if (ex_redirect) begin
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (w_hazard) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // Select names the stage the producer occupies once the consumer is in EX.
    assign w_fwd_a_next = (w_hit_a && !bubble_ex) ? FSEL_W'(stage_to_fsel(w_stage_a + 1))
                                                  : FSEL_W'(FSEL_REGFILE);
    assign w_fwd_b_next = (w_hit_b && !bubble_ex) ? FSEL_W'(stage_to_fsel(w_stage_b + 1))
                                                  : FSEL_W'(FSEL_REGFILE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= '0;
            fwd_b <= '0;
        end else begin
            fwd_a <= w_fwd_a_next;
            fwd_b <= w_fwd_b_next;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_ifid && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit at default parameters; expected forward selects
// are queued when an instruction is driven and compared once it has entered EX.
module tb_hazard_unit;

    localparam int FSEL_W = 2;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic       red;
        logic [2:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } row_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
    } fwd_exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [4:0]        id_rd;
    logic              id_regwen;
    logic              id_is_load;
    logic              ex_redirect;
    logic              stall;
    logic              flush_ifid;
    logic              bubble_ex;
    logic [FSEL_W-1:0] fwd_a;
    logic [FSEL_W-1:0] fwd_b;
`ifdef HAZARD_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    fwd_exp_t fwdQ[$];
    int       vectors     = 0;
    int       miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_regwen   (id_regwen),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .bubble_ex   (bubble_ex),
        .fwd_a       (fwd_a),
`ifdef HAZARD_STATS_EN
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`else
        .fwd_b       (fwd_b)
`endif
    );

    // Row fields: valid, rs1, rs2, rs1_used, rs2_used, rd, regwen, is_load, redirect,
    // expected {stall, flush_ifid, bubble_ex}, expected fwd_a, expected fwd_b.
    function automatic row_t mk(input int v, input int rs1, input int rs2, input int u1,
                                input int u2, input int rd, input int wen, input int ld,
                                input int red, input int ctl, input int fa, input int fb);
        row_t r;
        r.v   = 1'(v);
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.u1  = 1'(u1);
        r.u2  = 1'(u2);
        r.rd  = 5'(rd);
        r.wen = 1'(wen);
        r.ld  = 1'(ld);
        r.red = 1'(red);
        r.ctl = 3'(ctl);
        r.fa  = 2'(fa);
        r.fb  = 2'(fb);
        return r;
    endfunction

    // Drives one ID slot shortly after a rising edge and waits for the falling edge.
    task automatic applyStimulus(input row_t r);
        id_valid    = r.v;
        id_rs1      = r.rs1;
        id_rs2      = r.rs2;
        id_rs1_used = r.u1;
        id_rs2_used = r.u2;
        id_rd       = r.rd;
        id_regwen   = r.wen;
        id_is_load  = r.ld;
        ex_redirect = r.red;
        @(negedge clk);
    endtask

    task automatic drain();
        id_valid    = 1'b0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_regwen   = 1'b0;
        id_is_load  = 1'b0;
        ex_redirect = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drain();
        vectors++;
        if ({stall, flush_ifid, bubble_ex} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctl: got %b want 000", {stall, flush_ifid, bubble_ex});
        end
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 3'b101, 0, 0));
        rows.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 3'b000, 3, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL load_use_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL load_use_fwd[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        drain();
    endtask

    task automatic test_load_gap();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 1, 9, 1, 0, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 5, 0, 1, 1, 6, 1, 0, 0, 3'b000, 3, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL load_gap_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL load_gap_fwd[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        drain();
    endtask

    task automatic test_alu_forward();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 1, 0, 1, 0, 5, 1, 0, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 3'b000, 2, 2));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL alu_fwd_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL alu_fwd_sel[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        drain();
    endtask

    task automatic test_youngest();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 1, 0, 1, 0, 7, 1, 0, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 2, 0, 1, 0, 7, 1, 0, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 3'b000, 2, 2));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL youngest_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL youngest_fwd[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        drain();
    endtask

    task automatic test_redirect();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 3, 0, 1, 0, 8, 1, 0, 1, 3'b011, 0, 0));
        rows.push_back(mk(1, 8, 3, 1, 1, 9, 1, 0, 0, 3'b000, 0, 3));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b011, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL redirect_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL redirect_fwd[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        drain();
    endtask

    task automatic test_x0_unused();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 0, 0, 1, 1, 9, 1, 1, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 1, 9, 1, 0, 10, 1, 0, 0, 3'b000, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL x0_unused_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL x0_unused_fwd[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        drain();
    endtask

    task automatic test_reset_midstall();
        row_t rows[$];
        fwd_exp_t e;
        rows.push_back(mk(1, 1, 0, 1, 0, 5, 1, 0, 0, 3'b000, 0, 0));
        rows.push_back(mk(1, 5, 0, 1, 0, 7, 1, 1, 0, 3'b000, 2, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            vectors++;
            if ({stall, flush_ifid, bubble_ex} !== rows[i].ctl) begin
                miscompares++;
                $display("[TB] FAIL midstall_ctl[%0d]: got %b want %b", i,
                         {stall, flush_ifid, bubble_ex}, rows[i].ctl);
            end
            fwdQ.push_back('{rows[i].fa, rows[i].fb});
            @(posedge clk);
            #1;
            e = fwdQ.pop_front();
            vectors++;
            if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
                miscompares++;
                $display("[TB] FAIL midstall_fwd[%0d]: got %0d/%0d want %0d/%0d", i,
                         fwd_a, fwd_b, e.a, e.b);
            end
        end
        applyStimulus(mk(1, 7, 0, 1, 0, 12, 1, 0, 0, 0, 0, 0));
        vectors++;
        if ({stall, flush_ifid, bubble_ex} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL midstall_pre: got %b want 101", {stall, flush_ifid, bubble_ex});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({stall, flush_ifid, bubble_ex, fwd_a, fwd_b} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL midstall_async: got %b want 0000000",
                     {stall, flush_ifid, bubble_ex, fwd_a, fwd_b});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({stall, flush_ifid, bubble_ex} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL midstall_post: got %b want 000", {stall, flush_ifid, bubble_ex});
        end
        fwdQ.push_back('{2'd0, 2'd0});
        @(posedge clk);
        #1;
        e = fwdQ.pop_front();
        vectors++;
        if ({fwd_a, fwd_b} !== {e.a, e.b}) begin
            miscompares++;
            $display("[TB] FAIL midstall_post_fwd: got %0d/%0d want %0d/%0d",
                     fwd_a, fwd_b, e.a, e.b);
        end
        drain();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        for (int p = 0; p < 3; p++) begin
            applyStimulus(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            applyStimulus(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            applyStimulus(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        for (int r = 0; r < 2; r++) begin
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vectors++;
        if ({stall_cnt, flush_cnt} !== {16'd3, 16'd2}) begin
            miscompares++;
            $display("[TB] FAIL stats_counts: got %0d/%0d want 3/2", stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        applyStimulus(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        applyStimulus(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({stall_cnt, flush_cnt, stall, flush_ifid, bubble_ex, fwd_a, fwd_b} !== 39'b0) begin
            miscompares++;
            $display("[TB] FAIL stats_reset: cnt %0d/%0d ctl %b fwd %0d/%0d want all 0",
                     stall_cnt, flush_cnt, {stall, flush_ifid, bubble_ex}, fwd_a, fwd_b);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
    endtask
`endif

    initial begin
        id_rs1 = '0;
        id_rs2 = '0;
        id_rd  = '0;
        test_reset();
        test_load_use();
        test_load_gap();
        test_alu_forward();
        test_youngest();
        test_redirect();
        test_x0_unused();
        test_reset_midstall();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
